// File: rtl/match_window_counter_pkg.sv
// Shared types for the match window counter: FSM state encoding and result-width helper.
// Combinational definitions only; no latency, no flow control.
package match_window_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A window of N cycles can hold 0..N matches, so N+1 distinct values.
    function automatic int res_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update latency.
// Never wraps: holds at all-ones; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/match_window_counter.sv
// Counts detector match pulses per fixed window, publishing each count with valid/ack, alarm, overrun and lifetime total.
// Result lands 1 cycle after the window's last sampled cycle; an unacked result is overwritten and flagged as overrun.
module match_window_counter
    import match_window_counter_pkg::*;
#(
    parameter  int WINDOW = 16,
    parameter  int THRESH = 4,
    parameter  int TOT_W  = 16,
    localparam int RES_W  = res_width(WINDOW),
    localparam int CNT_W  = $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             match,
    input  logic             rd_ack,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             alarm,
    output logic             overrun,
    output logic [TOT_W-1:0] total
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] win_cnt;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_sum;
    logic             counting;
    logic             win_end;
    logic             take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear deliberately leaves the FSM alone; only enable moves it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable)  state_nxt = ST_RUN;
            ST_RUN:  if (!enable) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign counting = (state == ST_RUN) && enable;
    assign win_end  = counting && (win_cnt == CNT_W'(WINDOW - 1));
    assign acc_sum  = acc + RES_W'(match);
    assign take     = rd_ack && result_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt      <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            alarm        <= 1'b0;
            overrun      <= 1'b0;
        end else if (clear) begin
            win_cnt      <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            alarm        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (counting && !win_end) begin
                win_cnt <= win_cnt + CNT_W'(1);
                acc     <= acc_sum;
            end else begin
                // Window end, or leaving RUN: the partial window is dropped.
                win_cnt <= '0;
                acc     <= '0;
            end

            if (win_end) begin
                result       <= acc_sum;
                result_valid <= 1'b1;
                alarm        <= (acc_sum >= RES_W'(THRESH));
                if (result_valid && !rd_ack) begin
                    overrun <= 1'b1;
                end
            end else if (take) begin
                result_valid <= 1'b0;
                alarm        <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W (TOT_W)
    ) u_total (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (counting && match),
        .cnt     (total)
    );

endmodule

// File: tb/tb_match_window_counter.sv
// Directed bench for match_window_counter (WINDOW=16, THRESH=4, TOT_W=4) with a cycle model and result scoreboard.
module tb_match_window_counter;

    localparam int WINDOW = 16;
    localparam int THRESH = 4;
    localparam int TOT_W  = 4;
    localparam int RES_W  = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             match = 1'b0;
    logic             rd_ack = 1'b0;
    logic [RES_W-1:0] result;
    logic             result_valid;
    logic             alarm;
    logic             overrun;
    logic [TOT_W-1:0] total;

    always #5 clk = ~clk;

    match_window_counter #(
        .WINDOW (WINDOW),
        .THRESH (THRESH),
        .TOT_W  (TOT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .clear        (clear),
        .match        (match),
        .rd_ack       (rd_ack),
        .result       (result),
        .result_valid (result_valid),
        .alarm        (alarm),
        .overrun      (overrun),
        .total        (total)
    );

    typedef struct {
        logic [RES_W-1:0] res;
        logic             alm;
        logic             ovr;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic             m_run;
    int               m_win;
    logic [RES_W-1:0] m_acc;
    logic [RES_W-1:0] m_res;
    logic             m_vld;
    logic             m_alm;
    logic             m_ovr;
    logic [TOT_W-1:0] m_tot;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_win = 0;
        m_acc = '0;
        m_res = '0;
        m_vld = 1'b0;
        m_alm = 1'b0;
        m_ovr = 1'b0;
        m_tot = '0;
        sb.delete();
    endtask

    task automatic step(input logic en, input logic cl, input logic mt, input logic ak);
        logic             we;
        logic [RES_W-1:0] sum;
        exp_t             e;
        @(negedge clk);
        enable = en;
        clear  = cl;
        match  = mt;
        rd_ack = ak;
        @(posedge clk);
        we = 1'b0;
        if (cl) begin
            m_win = 0;
            m_acc = '0;
            m_res = '0;
            m_vld = 1'b0;
            m_alm = 1'b0;
            m_ovr = 1'b0;
            m_tot = '0;
        end else if (m_run && en) begin
            if (mt && (m_tot != 4'hF)) m_tot = m_tot + 4'd1;
            sum = m_acc + RES_W'(mt);
            if (m_win == WINDOW - 1) begin
                we = 1'b1;
                if (m_vld && !ak) m_ovr = 1'b1;
                m_res = sum;
                m_vld = 1'b1;
                m_alm = (sum >= RES_W'(THRESH));
                m_acc = '0;
                m_win = 0;
                e.res = sum;
                e.alm = m_alm;
                e.ovr = m_ovr;
                sb.push_back(e);
            end else begin
                m_acc = sum;
                m_win++;
                if (ak && m_vld) begin
                    m_vld = 1'b0;
                    m_alm = 1'b0;
                end
            end
        end else begin
            m_acc = '0;
            m_win = 0;
            if (ak && m_vld) begin
                m_vld = 1'b0;
                m_alm = 1'b0;
            end
        end
        m_run = en;
        #1;
        if (we && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_result", 16'(result), 16'(e.res));
            chk("sb_alarm", 16'(alarm), 16'(e.alm));
            chk("sb_overrun", 16'(overrun), 16'(e.ovr));
        end
        chk("valid", 16'(result_valid), 16'(m_vld));
        chk("alarm", 16'(alarm), 16'(m_alm));
        chk("overrun", 16'(overrun), 16'(m_ovr));
        chk("total", 16'(total), 16'(m_tot));
        chk("result", 16'(result), 16'(m_res));
    endtask

    task automatic run_window(input logic [15:0] mask, input logic ack_end);
        for (int i = 0; i < WINDOW; i++) begin
            step(1'b1, 1'b0, mask[i], (i == WINDOW - 1) ? ack_end : 1'b0);
        end
    endtask

    initial begin
        model_reset();

        // 1: reset held with enable and match active
        enable  = 1'b1;
        match   = 1'b1;
        reset_n = 1'b0;
        repeat (20) @(negedge clk);
        chk("t1_result", 16'(result), 16'd0);
        chk("t1_valid", 16'(result_valid), 16'd0);
        chk("t1_alarm", 16'(alarm), 16'd0);
        chk("t1_overrun", 16'(overrun), 16'd0);
        chk("t1_total", 16'(total), 16'd0);
        enable  = 1'b0;
        match   = 1'b0;
        reset_n = 1'b1;

        // 2: five matches in a window, then acknowledge
        step(1'b1, 1'b0, 1'b0, 1'b0);
        run_window(16'h001F, 1'b0);
        chk("t2_result", 16'(result), 16'd5);
        chk("t2_valid", 16'(result_valid), 16'd1);
        chk("t2_alarm", 16'(alarm), 16'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_ack_valid", 16'(result_valid), 16'd0);
        chk("t2_ack_alarm", 16'(alarm), 16'd0);
        chk("t2_ack_result", 16'(result), 16'd5);

        // 3: overrun on unacked window, then ack coincident with window end
        for (int i = 1; i < WINDOW; i++) step(1'b1, 1'b0, (i <= 3), 1'b0);
        chk("t3_first", 16'(result), 16'd3);
        chk("t3_first_alarm", 16'(alarm), 16'd0);
        chk("t3_first_ovr", 16'(overrun), 16'd0);
        run_window(16'h0300, 1'b0);
        chk("t3_second", 16'(result), 16'd2);
        chk("t3_overrun", 16'(overrun), 16'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_clr_ovr", 16'(overrun), 16'd0);
        chk("t3_clr_total", 16'(total), 16'd0);
        run_window(16'h0007, 1'b0);
        run_window(16'h0005, 1'b1);
        chk("t3_ackend_result", 16'(result), 16'd2);
        chk("t3_ackend_valid", 16'(result_valid), 16'd1);
        chk("t3_ackend_ovr", 16'(overrun), 16'd0);

        // 4: match only on the last cycle; partial window discarded on disable
        run_window(16'h8000, 1'b0);
        chk("t4_last", 16'(result), 16'd1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, (i % 2 == 0), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_idle_result", 16'(result), 16'd1);
        chk("t4_idle_valid", 16'(result_valid), 16'd1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_window(16'h0003, 1'b0);
        chk("t4_fresh", 16'(result), 16'd2);

        // 5: total saturation, then clear
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_total_sat", 16'(total), 16'd15);
        chk("t5_overrun", 16'(overrun), 16'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_clr_total", 16'(total), 16'd0);
        chk("t5_clr_ovr", 16'(overrun), 16'd0);
        chk("t5_clr_valid", 16'(result_valid), 16'd0);

        // 6: async reset between edges, mid-window
        run_window(16'h00F0, 1'b0);
        chk("t6_pre_result", 16'(result), 16'd4);
        chk("t6_pre_alarm", 16'(alarm), 16'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, (i < 4), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_result", 16'(result), 16'd0);
        chk("t6_valid", 16'(result_valid), 16'd0);
        chk("t6_alarm", 16'(alarm), 16'd0);
        chk("t6_overrun", 16'(overrun), 16'd0);
        chk("t6_total", 16'(total), 16'd0);
        enable = 1'b0;
        match  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run_window(16'h0001, 1'b0);
        chk("t6_resume", 16'(result), 16'd1);
        chk("t6_resume_total", 16'(total), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
